// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an asynchronous PWM input between accepted
// rising edges and derives a 0..15 duty estimate with a 5-step restoring divider.
module pwm_duty_meter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [3:0]       duty,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  localparam int               DIV_W     = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       DIV_STEPS = 3'd5;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] per_next;
  logic [CNT_W-1:0] hi_next;
  logic [1:0]       state;
  logic [CNT_W-1:0] cap_hi;
  logic [CNT_W-1:0] cap_per;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dsor;
  logic [4:0]       quo;
  logic [2:0]       step;
  logic             stuck_hit;
  logic             div_ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Both counters restart at 1 on the rise cycle itself, so a capture on the
  // next rise reads H+L for the period and H for the high time.
  always_comb begin
    per_next = per_cnt;
    hi_next  = hi_cnt;
    if (rise) begin
      per_next = CNT_ONE;
      hi_next  = CNT_ONE;
    end else begin
      if (per_cnt != CNT_MAX) begin
        per_next = per_cnt + CNT_ONE;
      end
      if (s2 && (hi_cnt != CNT_MAX)) begin
        hi_next = hi_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      per_cnt <= per_next;
      hi_cnt  <= hi_next;
    end
  end

  assign stuck_hit = (state != IDLE) && (per_next == CNT_MAX);
  assign div_ge    = (rem >= dsor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap_hi    <= '0;
      cap_per   <= '0;
      rem       <= '0;
      dsor      <= '0;
      quo       <= '0;
      step      <= '0;
      high_time <= '0;
      period    <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      if (stuck_hit) begin
        // No edge for a full counter range: report the static level, abort.
        stuck <= 1'b1;
        duty  <= s2 ? 4'hF : 4'h0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (rise) begin
              cap_hi  <= hi_cnt;
              cap_per <= per_cnt;
              rem     <= {hi_cnt, 4'b0000};
              dsor    <= {per_cnt, 4'b0000};
              quo     <= '0;
              step    <= '0;
              state   <= BUSY;
            end
          end
          BUSY: begin
            if (rise) begin
              overrun <= 1'b1;
            end
            if (step == DIV_STEPS) begin
              high_time <= cap_hi;
              period    <= cap_per;
              duty      <= quo[4] ? 4'hF : quo[3:0];
              valid     <= 1'b1;
              stuck     <= 1'b0;
              state     <= ARMED;
            end else begin
              // Divisor starts at per<<4 and halves each step: q4 first.
              rem  <= div_ge ? (rem - dsor) : rem;
              quo  <= {quo[3:0], div_ge};
              dsor <= dsor >> 1;
              step <= step + 3'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized and directed bench for pwm_duty_meter; a clock-edge indexed
// reference model derives every output from the sampled input history.
module tb_pwm_duty_meter;

  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int MAXE  = 32768;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic [3:0]       duty;
  logic             valid;
  logic             stuck;
  logic             overrun;

  int tests = 0;
  int fails = 0;

  // Model: p_hist[k] is the pwm level the DUT sampled at clock edge k.
  bit p_hist [0:MAXE-1];
  int n = 0;
  int m_mode = 0;  // 0 unarmed, 1 armed, 2 dividing
  int m_last_rise = 0;
  int m_cap_edge = 0;
  int m_cap_hi = 0;
  int m_cap_per = 0;
  int e_hi = 0, e_per = 0, e_duty = 0, e_valid = 0, e_stuck = 0, e_ovr = 0;

  // Observations of DUT behaviour for the directed literal checks.
  int lv_hi = 0, lv_per = 0, lv_duty = 0;
  int valid_cnt = 0, ovr_cnt = 0;
  int stuck_edge = -1, stuck_rise = 0;
  bit prev_stuck = 1'b0;

  pwm_duty_meter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .duty      (duty),
    .valid     (valid),
    .stuck     (stuck),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic int high_samples(input int from, input int to);
    int s = 0;
    for (int j = from; j <= to; j++) begin
      if (j >= 0 && p_hist[j]) s++;
    end
    return s;
  endfunction

  task automatic model_step(input bit r, input bit pin);
    bit rz;
    int prev_mode;
    int d;
    n++;
    if (n >= MAXE) begin
      $display("FAIL edge_budget: got %0d, expected below %0d", n, MAXE);
      $fatal(1);
    end
    p_hist[n] = r ? 1'b0 : pin;
    e_valid = 0;
    e_ovr = 0;
    if (r) begin
      m_mode = 0;
      e_hi = 0; e_per = 0; e_duty = 0; e_stuck = 0;
      return;
    end
    rz = (n >= 3) && p_hist[n-2] && !p_hist[n-3];
    if (m_mode != 0 && !rz && (n - m_last_rise == MAXV - 1)) begin
      e_stuck = 1;
      e_duty = p_hist[n-2] ? 15 : 0;
      m_mode = 0;
    end else begin
      prev_mode = m_mode;
      if (m_mode == 2 && n == m_cap_edge + 6) begin
        e_hi = m_cap_hi;
        e_per = m_cap_per;
        d = (16 * m_cap_hi) / m_cap_per;
        e_duty = (d > 15) ? 15 : d;
        e_valid = 1;
        e_stuck = 0;
        m_mode = 1;
      end
      if (rz) begin
        case (prev_mode)
          0: m_mode = 1;
          1: begin
            m_cap_per = n - m_last_rise;
            m_cap_hi = high_samples(m_last_rise - 2, n - 3);
            m_cap_edge = n;
            m_mode = 2;
          end
          default: e_ovr = 1;
        endcase
      end
    end
    if (rz) m_last_rise = n;
  endtask

  // Compare process: model advances on each rising edge, DUT checked on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, pwm_in);
      @(negedge clk);
      check("high_time", int'(high_time), e_hi);
      check("period", int'(period), e_per);
      check("duty", int'(duty), e_duty);
      check("valid", int'(valid), e_valid);
      check("stuck", int'(stuck), e_stuck);
      check("overrun", int'(overrun), e_ovr);
      if (valid) begin
        lv_hi = int'(high_time);
        lv_per = int'(period);
        lv_duty = int'(duty);
        valid_cnt++;
      end
      if (overrun) ovr_cnt++;
      if (stuck && !prev_stuck) begin
        stuck_edge = n;
        stuck_rise = m_last_rise;
      end
      prev_stuck = stuck;
    end
  end

  task automatic hold(input bit v, input int c);
    pwm_in = v;
    repeat (c) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic check_last(input string tag, input int per, input int hi, input int dt);
    check({tag, "_period"}, lv_per, per);
    check({tag, "_high_time"}, lv_hi, hi);
    check({tag, "_duty"}, lv_duty, dt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_time"}, int'(high_time), 0);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_stuck"}, int'(stuck), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int h;
    int l;
    rst = 1'b1;
    pwm_in = 1'b0;
    @(negedge clk);
    #2;
    hold(0, 4);
    check_all_zero("reset");
    rst = 1'b0;
    hold(0, 4);

    // High 3 / low 5: first rise only arms.
    valid_cnt = 0;
    repeat (10) begin hold(1, 3); hold(0, 5); end
    check("hl35_valid_count", valid_cnt, 8);
    check_last("hl35", 8, 3, 6);

    repeat (4) begin hold(1, 1); hold(0, 15); end
    check_last("hl1_15", 16, 1, 1);
    repeat (4) begin hold(1, 15); hold(0, 1); end
    check_last("hl15_1", 16, 15, 15);

    // Period 4 is too short for the divider: every other rise is dropped.
    ovr_cnt = 0;
    valid_cnt = 0;
    repeat (8) begin hold(1, 2); hold(0, 2); end
    check("hl22_overruns", ovr_cnt, 4);
    check("hl22_valid_count", valid_cnt, 3);
    check_last("hl22", 4, 2, 8);
    hold(0, 4);

    // Stuck low, then recovery after two rises.
    stuck_edge = -1;
    hold(1, 3); hold(0, 5); hold(1, 3); hold(0, 300);
    check("stuck_low_flag", int'(stuck), 1);
    check("stuck_low_duty", int'(duty), 0);
    check("stuck_low_delay", stuck_edge - stuck_rise, 254);
    repeat (2) begin hold(1, 3); hold(0, 5); end
    hold(0, 4);
    check("stuck_recover_flag", int'(stuck), 0);
    check_last("stuck_recover", 8, 3, 6);

    // Stuck high.
    hold(1, 300);
    check("stuck_high_flag", int'(stuck), 1);
    check("stuck_high_duty", int'(duty), 15);

    // Reset three clocks into a division.
    hold(0, 5); hold(1, 3); hold(0, 5); hold(1, 3); hold(0, 3);
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    hold(0, 4);
    rst = 1'b0;
    valid_cnt = 0;
    hold(0, 3);
    repeat (2) begin hold(1, 3); hold(0, 5); end
    hold(0, 4);
    check("post_reset_valid_count", valid_cnt, 1);
    check_last("post_reset", 8, 3, 6);

    // One-clock glitch inside a low phase counts as a real rise.
    hold(1, 4); hold(0, 3); hold(1, 1); hold(0, 6); hold(1, 2);
    check_last("glitch_a", 7, 4, 9);
    hold(0, 10);
    check_last("glitch_b", 7, 1, 2);

    // Random waveforms with occasional stuck-length gaps and resets.
    repeat (150) begin
      h = ($urandom_range(0, 24) == 0) ? int'($urandom_range(240, 290)) : int'($urandom_range(1, 20));
      l = ($urandom_range(0, 19) == 0) ? int'($urandom_range(240, 300)) : int'($urandom_range(1, 20));
      hold(1, h);
      hold(0, l);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        hold(0, 3);
        rst = 1'b0;
      end
    end
    hold(0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
